// File: rtl/segre_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | segre_pkg : shared types and constants for the CSR access unit     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package segre_pkg;

    localparam int CSR_SIZE  = 12;
    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        CSR_ILL = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        CSR_IDLE  = 2'd0,
        CSR_READ  = 2'd1,
        CSR_WRITE = 2'd2,
        CSR_RESP  = 2'd3
    } csr_fsm_state_e;

    localparam logic [CSR_SIZE-1:0] CSR_CYCLE_ADDR  = 12'hC00;
    localparam logic [CSR_SIZE-1:0] CSR_CYCLEH_ADDR = 12'hC80;
    // Top two address bits equal to this mark a read-only CSR
    localparam logic [1:0]          CSR_RO_BITS     = 2'b11;

endpackage
`default_nettype wire

// File: rtl/segre_csr_alu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | segre_csr_alu : Zicsr new-value, write-needed and illegal decode   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module segre_csr_alu
    import segre_pkg::*;
#(
    parameter int DATA_W = WORD_SIZE
) (
    input  csr_op_e           i_op,
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_operand,
    input  logic              i_src_zero,
    input  logic              i_read_only,
    output logic [DATA_W-1:0] o_new,
    output logic              o_write_needed,
    output logic              o_illegal
);

    always_comb begin
        o_new = i_operand;
        case (i_op)
            CSR_RS:  o_new = i_old | i_operand;
            CSR_RC:  o_new = i_old & ~i_operand;
            default: o_new = i_operand;
        endcase
        // RW always writes, even a zero; RS/RC with a zero source only read
        o_write_needed = (i_op == CSR_RW) | ~i_src_zero;
        o_illegal      = (i_op == CSR_ILL) | (o_write_needed & i_read_only);
    end

endmodule
`default_nettype wire

// File: rtl/segre_csr_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | segre_csr_unit : CSR read-modify-write initiator (one op in flight)|
// | Optional cycle counter at 0xC00/0xC80 under SEGRE_CSR_CYCLE_EN     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module segre_csr_unit
    import segre_pkg::*;
#(
    parameter int ADDR_W = CSR_SIZE,
    parameter int DATA_W = WORD_SIZE
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_operand_i,
    input  logic              req_src_zero_i,
    output logic [ADDR_W-1:0] csr_raddr_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic              csr_we_o,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_illegal_o
);

    csr_fsm_state_e    r_state, w_next;
    csr_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_operand;
    logic              r_src_zero;
    logic [DATA_W-1:0] r_old;
    logic [DATA_W-1:0] r_new;
    logic              r_illegal;
    logic              r_we;
    logic              r_rsp_valid;

    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_new;
    logic              w_write_needed;
    logic              w_illegal;
    logic              w_write_go;

`ifdef SEGRE_CSR_CYCLE_EN
    logic [63:0] r_cycle;

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) r_cycle <= '0;
        else       r_cycle <= r_cycle + 64'd1;
    end

    always_comb begin
        w_rdata = csr_rdata_i;
        if (r_addr == CSR_CYCLE_ADDR)
            w_rdata = DATA_W'(r_cycle[31:0]);
        else if (r_addr == CSR_CYCLEH_ADDR)
            w_rdata = DATA_W'(r_cycle[63:32]);
    end
`else
    assign w_rdata = csr_rdata_i;
`endif

    segre_csr_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op           (r_op),
        .i_old          (w_rdata),
        .i_operand      (r_operand),
        .i_src_zero     (r_src_zero),
        .i_read_only    (r_addr[ADDR_W-1 -: 2] == CSR_RO_BITS),
        .o_new          (w_new),
        .o_write_needed (w_write_needed),
        .o_illegal      (w_illegal)
    );

    assign w_write_go = w_write_needed & ~w_illegal;

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) r_state <= CSR_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CSR_IDLE:  if (req_valid_i) w_next = CSR_READ;
            CSR_READ:  w_next = w_write_go ? CSR_WRITE : CSR_RESP;
            CSR_WRITE: w_next = CSR_RESP;
            CSR_RESP:  if (rsp_ready_i) w_next = CSR_IDLE;
            default:   w_next = CSR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            r_op        <= CSR_ILL;
            r_addr      <= '0;
            r_operand   <= '0;
            r_src_zero  <= 1'b0;
            r_old       <= '0;
            r_new       <= '0;
            r_illegal   <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                CSR_IDLE: begin
                    if (req_valid_i) begin
                        r_op       <= csr_op_e'(req_op_i);
                        r_addr     <= req_addr_i;
                        r_operand  <= req_operand_i;
                        r_src_zero <= req_src_zero_i;
                    end
                end
                CSR_READ: begin
                    r_old       <= w_rdata;
                    r_new       <= w_new;
                    r_illegal   <= w_illegal;
                    r_we        <= w_write_go;
                    r_rsp_valid <= ~w_write_go;
                end
                CSR_WRITE: begin
                    r_we        <= 1'b0;
                    r_rsp_valid <= 1'b1;
                end
                CSR_RESP: begin
                    if (rsp_ready_i) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Read and write address share the latched request address
    assign req_ready_o   = (r_state == CSR_IDLE);
    assign csr_raddr_o   = r_addr;
    assign csr_waddr_o   = r_addr;
    assign csr_wdata_o   = r_new;
    assign csr_we_o      = r_we;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_old;
    assign rsp_illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_segre_csr_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_segre_csr_unit : directed self-checking bench for segre_csr_unit|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_segre_csr_unit;

    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_op_i = 2'b00;
    logic [11:0] req_addr_i = '0;
    logic [31:0] req_operand_i = '0;
    logic        req_src_zero_i = 1'b0;
    logic [11:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_data_o;
    logic        rsp_illegal_o;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_total = 0;
    logic [11:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [63:0] tb_cyc;
    logic [31:0] mem [0:4095];

    always #5 clk_i = ~clk_i;

    segre_csr_unit dut (
        .clk_i          (clk_i),
        .rsn_i          (rsn_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_addr_i     (req_addr_i),
        .req_operand_i  (req_operand_i),
        .req_src_zero_i (req_src_zero_i),
        .csr_raddr_o    (csr_raddr_o),
        .csr_rdata_i    (csr_rdata_i),
        .csr_we_o       (csr_we_o),
        .csr_waddr_o    (csr_waddr_o),
        .csr_wdata_o    (csr_wdata_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .rsp_illegal_o  (rsp_illegal_o)
    );

    // CSR file model: combinational read, write on the clock edge
    assign csr_rdata_i = mem[csr_raddr_o];

    always @(posedge clk_i) begin
        if (csr_we_o) begin
            mem[csr_waddr_o] = csr_wdata_o;
            wr_addr  = csr_waddr_o;
            wr_data  = csr_wdata_o;
            wr_total = wr_total + 1;
        end
    end

    always @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 64'd1;
    end

    // Issue one request; lat counts edges from the accept edge (accept = 1)
    task automatic do_op(input logic [1:0] op, input logic [11:0] addr,
                         input logic [31:0] opnd, input logic sz,
                         output int lat, output logic [31:0] data,
                         output logic ill, output int nwr,
                         output logic [63:0] acc_cyc);
        int w0;
        @(negedge clk_i);
        w0 = wr_total;
        req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr;
        req_operand_i = opnd; req_src_zero_i = sz;
        @(posedge clk_i); #1;
        acc_cyc = tb_cyc;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        data = rsp_data_o;
        ill  = rsp_illegal_o;
        if (rsp_ready_i) begin
            @(posedge clk_i); #1;
        end
        nwr = wr_total - w0;
    endtask

    task automatic apply_reset();
        rsn_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rsn_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 7;
        if (csr_we_o !== 1'b0)      begin n_fail++; $display("FAIL reset_we got %b want 0", csr_we_o); end
        if (rsp_valid_o !== 1'b0)   begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
        if (rsp_data_o !== 32'h0)   begin n_fail++; $display("FAIL reset_rsp_data got %h want 0", rsp_data_o); end
        if (rsp_illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", rsp_illegal_o); end
        if (csr_raddr_o !== 12'h0)  begin n_fail++; $display("FAIL reset_raddr got %h want 0", csr_raddr_o); end
        if (csr_waddr_o !== 12'h0)  begin n_fail++; $display("FAIL reset_waddr got %h want 0", csr_waddr_o); end
        if (req_ready_o !== 1'b1)   begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
    endtask

    task automatic test_rw();
        int lat, nwr; logic [31:0] d; logic ill; logic [63:0] c;
        mem[12'h300] = 32'hAAAA_0000;
        do_op(2'b01, 12'h300, 32'h0000_1234, 1'b0, lat, d, ill, nwr, c);
        n_checks += 7;
        if (lat !== 3)              begin n_fail++; $display("FAIL rw_latency got %0d want 3", lat); end
        if (d !== 32'hAAAA_0000)    begin n_fail++; $display("FAIL rw_data got %h want aaaa0000", d); end
        if (ill !== 1'b0)           begin n_fail++; $display("FAIL rw_illegal got %b want 0", ill); end
        if (nwr !== 1)              begin n_fail++; $display("FAIL rw_writes got %0d want 1", nwr); end
        if (wr_addr !== 12'h300)    begin n_fail++; $display("FAIL rw_waddr got %h want 300", wr_addr); end
        if (wr_data !== 32'h1234)   begin n_fail++; $display("FAIL rw_wdata got %h want 1234", wr_data); end
        if (req_ready_o !== 1'b1)   begin n_fail++; $display("FAIL rw_ready_after got %b want 1", req_ready_o); end
    endtask

    task automatic test_rs_rc();
        int lat, nwr; logic [31:0] d; logic ill; logic [63:0] c;
        mem[12'h304] = 32'h0000_0F0F;
        do_op(2'b10, 12'h304, 32'h0000_00F0, 1'b0, lat, d, ill, nwr, c);
        n_checks += 3;
        if (d !== 32'h0F0F)         begin n_fail++; $display("FAIL rs_data got %h want 0f0f", d); end
        if (nwr !== 1)              begin n_fail++; $display("FAIL rs_writes got %0d want 1", nwr); end
        if (wr_data !== 32'h0FFF)   begin n_fail++; $display("FAIL rs_wdata got %h want 0fff", wr_data); end
        do_op(2'b11, 12'h304, 32'h0000_000F, 1'b0, lat, d, ill, nwr, c);
        n_checks += 4;
        if (d !== 32'h0FFF)         begin n_fail++; $display("FAIL rc_data got %h want 0fff", d); end
        if (wr_data !== 32'h0FF0)   begin n_fail++; $display("FAIL rc_wdata got %h want 0ff0", wr_data); end
        if (lat !== 3)              begin n_fail++; $display("FAIL rc_latency got %0d want 3", lat); end
        if (mem[12'h304] !== 32'h0FF0) begin n_fail++; $display("FAIL rc_file got %h want 0ff0", mem[12'h304]); end
    endtask

    task automatic test_zero_src();
        int lat, nwr; logic [31:0] d; logic ill; logic [63:0] c;
        mem[12'h340] = 32'h5555_AAAA;
        do_op(2'b10, 12'h340, 32'hFFFF_FFFF, 1'b1, lat, d, ill, nwr, c);
        n_checks += 4;
        if (lat !== 2)              begin n_fail++; $display("FAIL zero_latency got %0d want 2", lat); end
        if (nwr !== 0)              begin n_fail++; $display("FAIL zero_writes got %0d want 0", nwr); end
        if (d !== 32'h5555_AAAA)    begin n_fail++; $display("FAIL zero_data got %h want 5555aaaa", d); end
        if (ill !== 1'b0)           begin n_fail++; $display("FAIL zero_illegal got %b want 0", ill); end
        // RW with a zero operand must still write zero
        mem[12'h341] = 32'hDEAD_BEEF;
        do_op(2'b01, 12'h341, 32'h0, 1'b1, lat, d, ill, nwr, c);
        n_checks += 2;
        if (nwr !== 1)              begin n_fail++; $display("FAIL rw0_writes got %0d want 1", nwr); end
        if (mem[12'h341] !== 32'h0) begin n_fail++; $display("FAIL rw0_file got %h want 0", mem[12'h341]); end
    endtask

    task automatic test_illegal();
        int lat, nwr; logic [31:0] d; logic ill; logic [63:0] c;
        mem[12'hC01] = 32'h0000_0077;
        do_op(2'b01, 12'hC01, 32'h5, 1'b0, lat, d, ill, nwr, c);
        n_checks += 4;
        if (ill !== 1'b1)           begin n_fail++; $display("FAIL ro_write_illegal got %b want 1", ill); end
        if (nwr !== 0)              begin n_fail++; $display("FAIL ro_write_writes got %0d want 0", nwr); end
        if (d !== 32'h77)           begin n_fail++; $display("FAIL ro_write_data got %h want 77", d); end
        if (lat !== 2)              begin n_fail++; $display("FAIL ro_write_latency got %0d want 2", lat); end
        mem[12'h300] = 32'h0000_1234;
        do_op(2'b00, 12'h300, 32'h9, 1'b0, lat, d, ill, nwr, c);
        n_checks += 3;
        if (ill !== 1'b1)           begin n_fail++; $display("FAIL op00_illegal got %b want 1", ill); end
        if (nwr !== 0)              begin n_fail++; $display("FAIL op00_writes got %0d want 0", nwr); end
        if (d !== 32'h1234)         begin n_fail++; $display("FAIL op00_data got %h want 1234", d); end
        do_op(2'b10, 12'hC01, 32'h0, 1'b1, lat, d, ill, nwr, c);
        n_checks += 2;
        if (ill !== 1'b0)           begin n_fail++; $display("FAIL ro_read_illegal got %b want 0", ill); end
        if (nwr !== 0)              begin n_fail++; $display("FAIL ro_read_writes got %0d want 0", nwr); end
    endtask

    task automatic test_backpressure();
        int lat, nwr, w0; logic [31:0] d; logic ill; logic [63:0] c;
        mem[12'h305] = 32'hCAFE_0001;
        mem[12'h306] = 32'h0;
        w0 = wr_total;
        rsp_ready_i = 1'b0;
        do_op(2'b01, 12'h305, 32'h0000_0042, 1'b0, lat, d, ill, nwr, c);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid_i = 1'b1; req_op_i = 2'b01;
                req_addr_i = 12'h306; req_operand_i = 32'h99; req_src_zero_i = 1'b0;
            end
            @(posedge clk_i); #1;
            n_checks += 3;
            if (rsp_valid_o !== 1'b1)        begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, rsp_valid_o); end
            if (rsp_data_o !== 32'hCAFE_0001) begin n_fail++; $display("FAIL bp_data[%0d] got %h want cafe0001", i, rsp_data_o); end
            if (req_ready_o !== 1'b0)        begin n_fail++; $display("FAIL bp_ready[%0d] got %b want 0", i, req_ready_o); end
        end
        req_valid_i = 1'b0;
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks += 2;
        if (rsp_valid_o !== 1'b0)   begin n_fail++; $display("FAIL bp_release_valid got %b want 0", rsp_valid_o); end
        if (req_ready_o !== 1'b1)   begin n_fail++; $display("FAIL bp_release_ready got %b want 1", req_ready_o); end
        repeat (4) @(posedge clk_i);
        #1;
        n_checks += 2;
        if (wr_total - w0 !== 1)    begin n_fail++; $display("FAIL bp_busy_writes got %0d want 1", wr_total - w0); end
        if (mem[12'h306] !== 32'h0) begin n_fail++; $display("FAIL bp_busy_file got %h want 0", mem[12'h306]); end
    endtask

    task automatic test_back_to_back();
        int lat, nwr; logic [31:0] d; logic ill; logic [63:0] c;
        mem[12'h320] = 32'h0000_0001;
        do_op(2'b10, 12'h320, 32'h0000_0002, 1'b0, lat, d, ill, nwr, c);
        do_op(2'b10, 12'h320, 32'h0000_0004, 1'b0, lat, d, ill, nwr, c);
        n_checks += 3;
        if (d !== 32'h3)            begin n_fail++; $display("FAIL b2b_data got %h want 3", d); end
        if (lat !== 3)              begin n_fail++; $display("FAIL b2b_latency got %0d want 3", lat); end
        if (mem[12'h320] !== 32'h7) begin n_fail++; $display("FAIL b2b_file got %h want 7", mem[12'h320]); end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        mem[12'h310] = 32'h0000_0011;
        w0 = wr_total;
        @(negedge clk_i);
        req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 12'h310;
        req_operand_i = 32'h99; req_src_zero_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks += 2;
        if (csr_we_o !== 1'b1)      begin n_fail++; $display("FAIL mid_we_before got %b want 1", csr_we_o); end
        if (csr_wdata_o !== 32'h99) begin n_fail++; $display("FAIL mid_wdata got %h want 99", csr_wdata_o); end
        #2 rsn_i = 1'b1;
        #1;
        n_checks += 3;
        if (csr_we_o !== 1'b0)      begin n_fail++; $display("FAIL mid_we_async got %b want 0", csr_we_o); end
        if (csr_waddr_o !== 12'h0)  begin n_fail++; $display("FAIL mid_waddr got %h want 0", csr_waddr_o); end
        if (req_ready_o !== 1'b1)   begin n_fail++; $display("FAIL mid_ready got %b want 1", req_ready_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        rsn_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks += 3;
        if (rsp_valid_o !== 1'b0)        begin n_fail++; $display("FAIL mid_no_rsp got %b want 0", rsp_valid_o); end
        if (wr_total - w0 !== 0)         begin n_fail++; $display("FAIL mid_writes got %0d want 0", wr_total - w0); end
        if (mem[12'h310] !== 32'h11)     begin n_fail++; $display("FAIL mid_file got %h want 11", mem[12'h310]); end
    endtask

`ifdef SEGRE_CSR_CYCLE_EN
    task automatic test_cycle();
        int lat, nwr; logic [31:0] d; logic ill; logic [63:0] c;
        apply_reset();
        repeat (7) @(posedge clk_i);
        do_op(2'b10, 12'hC00, 32'h0, 1'b1, lat, d, ill, nwr, c);
        n_checks += 2;
        if (d !== c[31:0])          begin n_fail++; $display("FAIL cycle_lo got %h want %h", d, c[31:0]); end
        if (ill !== 1'b0)           begin n_fail++; $display("FAIL cycle_lo_illegal got %b want 0", ill); end
        @(negedge clk_i);
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.r_cycle;
        do_op(2'b10, 12'hC80, 32'h0, 1'b1, lat, d, ill, nwr, c);
        n_checks += 1;
        if (d !== 32'h1)            begin n_fail++; $display("FAIL cycle_hi got %h want 1", d); end
        do_op(2'b01, 12'hC00, 32'h5, 1'b0, lat, d, ill, nwr, c);
        n_checks += 1;
        if (ill !== 1'b1)           begin n_fail++; $display("FAIL cycle_write_illegal got %b want 1", ill); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        test_reset();
        test_rw();
        test_rs_rc();
        test_zero_src();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_write();
`ifdef SEGRE_CSR_CYCLE_EN
        test_cycle();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
